// File: rtl/conv_tile_pkg.sv
// conv_tile_pkg: shared types and helpers for the conv tile MAC engine.
//   state_t     - engine FSM states
//   calc_row_w  - pixels carried per input beat (PARA_Y + KMAX - 1)
//   k_valid     - run-time kernel size check (odd, 1..KMAX)
//   shift_sat   - arithmetic right shift followed by signed saturation
package conv_tile_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_W   = 3'd1,
    LOAD_PIX = 3'd2,
    COMPUTE  = 3'd3,
    OUTPUT   = 3'd4
  } state_t;

  function automatic int calc_row_w(input int para_y, input int kmax);
    return para_y + kmax - 1;
  endfunction

  function automatic logic k_valid(input int unsigned k, input int unsigned kmax);
    return (k != 0) && (k % 2 == 1) && (k <= kmax);
  endfunction

  // Operates on a 64-bit view so it serves any ACC_W <= 64 / DATA_W < 64.
  function automatic logic signed [63:0] shift_sat(input logic signed [63:0] a,
                                                   input int unsigned       sh,
                                                   input int unsigned       dw);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a >>> sh;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/conv_tile_if.sv
// conv_tile_if: input beat stream and output tile stream of the engine.
//   in_valid/in_ready/in_data    - pixel/weight beats into the engine
//   out_valid/out_ready/out_data - requantised tile out of the engine
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. A source holds valid and payload steady until that edge; ready
// may change freely and never depends combinationally on valid.
interface conv_tile_if #(
  parameter int DATA_W = 16,
  parameter int ROW_W  = 7,
  parameter int NOUT   = 9
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic [ROW_W*DATA_W-1:0]  in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [NOUT*DATA_W-1:0]   out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/conv_tile_pe.sv
// conv_tile_pe: one output-pixel accumulator.
//   clk, rst  - clock, synchronous active-high reset
//   i_clr     - zero the accumulator (before a channel pass)
//   i_en      - add i_pix * i_wgt this cycle
//   i_pix     - signed pixel operand
//   i_wgt     - signed weight operand
//   o_acc     - signed accumulator value (wraps on overflow)
module conv_tile_pe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_pix,
  input  logic signed [DATA_W-1:0] i_wgt,
  output logic signed [ACC_W-1:0]  o_acc
);
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_prod = i_pix * i_wgt;

  always_ff @(posedge clk) begin
    if (rst)       r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= r_acc + {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/conv_tile_mac_engine.sv
// conv_tile_mac_engine: PARA_X x PARA_Y conv tile for run-time odd K <= KMAX.
//   clk, rst        - clock, synchronous active-high reset
//   i_start         - begin a channel pass (honoured only in IDLE)
//   i_kernel_size   - K, sampled with i_start
//   i_clear_acc     - zero accumulators before the pass, sampled with i_start
//   i_last_ch       - emit the tile after the pass, sampled with i_start
//   bus (slave)     - input beats (K*K weights then PARA_X+K-1 rows) and tile out
//   o_busy          - FSM not in IDLE
//   o_pass_done     - pulse on the final COMPUTE cycle
//   o_cfg_err       - pulse the cycle after a start with an illegal K
//   o_state         - current FSM state for observation
module conv_tile_mac_engine
  import conv_tile_pkg::*;
#(
  parameter int PARA_X = 3,
  parameter int PARA_Y = 3,
  parameter int KMAX   = 5,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int SHIFT  = 8,
  parameter int KS_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [KS_W-1:0] i_kernel_size,
  input  logic            i_clear_acc,
  input  logic            i_last_ch,
  conv_tile_if.slave      bus,
  output logic            o_busy,
  output logic            o_pass_done,
  output logic            o_cfg_err,
  output state_t          o_state
);
  localparam int ROW_W = calc_row_w(PARA_Y, KMAX);
  localparam int NROW  = PARA_X + KMAX - 1;
  localparam int KI_W  = (KMAX  > 1) ? $clog2(KMAX)  : 1;
  localparam int RI_W  = (NROW  > 1) ? $clog2(NROW)  : 1;
  localparam int CI_W  = (ROW_W > 1) ? $clog2(ROW_W) : 1;
  localparam int NOUT  = PARA_X * PARA_Y;

  state_t                    r_state, w_next;
  logic [KS_W-1:0]           r_k;
  logic                      r_last;
  logic [KI_W-1:0]           r_ky, r_kx;
  logic [RI_W-1:0]           r_rcnt;
  logic                      r_out_valid;
  logic [NOUT*DATA_W-1:0]    r_out_data;
  logic                      r_cfg_err;
  logic signed [DATA_W-1:0]  r_w   [KMAX][KMAX];
  logic signed [DATA_W-1:0]  r_row [NROW][ROW_W];

  logic                      w_k_ok, w_accept, w_fire, w_tap_last, w_row_last;
  logic                      w_clr, w_en, w_pass_done;
  logic [KI_W-1:0]           w_klast;
  logic [RI_W-1:0]           w_rlast;
  logic [NOUT*DATA_W-1:0]    w_sat_flat;

  assign w_k_ok     = k_valid(32'(i_kernel_size), KMAX);
  assign w_accept   = (r_state == LOAD_W) || (r_state == LOAD_PIX);
  assign w_fire     = w_accept && bus.in_valid;
  assign w_klast    = KI_W'(r_k - 1'b1);
  assign w_rlast    = RI_W'(PARA_X + int'(r_k) - 2);
  assign w_tap_last = (r_ky == w_klast) && (r_kx == w_klast);
  assign w_row_last = (r_rcnt == w_rlast);
  assign w_clr      = (r_state == IDLE) && i_start && w_k_ok && i_clear_acc;
  assign w_en       = (r_state == COMPUTE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_pass_done = 1'b0;
    case (r_state)
      IDLE:     if (i_start && w_k_ok) w_next = LOAD_W;
      LOAD_W:   if (w_fire && w_tap_last) w_next = LOAD_PIX;
      LOAD_PIX: if (w_fire && w_row_last) w_next = COMPUTE;
      COMPUTE: begin
        if (w_tap_last) begin
          w_pass_done = 1'b1;
          w_next      = r_last ? OUTPUT : IDLE;
        end
      end
      OUTPUT:   if (r_out_valid && bus.out_ready) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Control registers. The (ky,kx) pair walks row-major both while loading
  // weights and while computing, and wraps to (0,0) after the last tap, so
  // COMPUTE starts from a clean origin without an explicit clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k         <= '0;
      r_last      <= 1'b0;
      r_ky        <= '0;
      r_kx        <= '0;
      r_rcnt      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= (r_state == IDLE) && i_start && !w_k_ok;
      case (r_state)
        IDLE: begin
          if (i_start && w_k_ok) begin
            r_k    <= i_kernel_size;
            r_last <= i_last_ch;
            r_ky   <= '0;
            r_kx   <= '0;
            r_rcnt <= '0;
          end
        end
        LOAD_W, COMPUTE: begin
          if (r_state == COMPUTE || w_fire) begin
            if (r_kx == w_klast) begin
              r_kx <= '0;
              r_ky <= (r_ky == w_klast) ? '0 : r_ky + 1'b1;
            end else begin
              r_kx <= r_kx + 1'b1;
            end
          end
        end
        LOAD_PIX: if (w_fire) r_rcnt <= r_rcnt + 1'b1;
        OUTPUT: begin
          // Capture once on the first OUTPUT cycle; held until accepted.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sat_flat;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Weight file and row buffer carry no reset: every entry read by a pass is
  // written earlier in that same pass.
  always_ff @(posedge clk) begin
    if (!rst && w_fire) begin
      if (r_state == LOAD_W) begin
        r_w[r_ky][r_kx] <= bus.in_data[DATA_W-1:0];
      end else begin
        for (int c = 0; c < ROW_W; c++)
          r_row[r_rcnt][c] <= bus.in_data[c*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar x = 0; x < PARA_X; x++) begin : g_x
    for (genvar y = 0; y < PARA_Y; y++) begin : g_y
      logic signed [ACC_W-1:0] w_acc;
      logic [RI_W-1:0]         w_ri;
      logic [CI_W-1:0]         w_ci;

      assign w_ri = RI_W'(x) + RI_W'(r_ky);
      assign w_ci = CI_W'(y) + CI_W'(r_kx);

      conv_tile_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_clr),
        .i_en  (w_en),
        .i_pix (r_row[w_ri][w_ci]),
        .i_wgt (r_w[r_ky][r_kx]),
        .o_acc (w_acc)
      );

      assign w_sat_flat[(x*PARA_Y+y)*DATA_W +: DATA_W] =
        DATA_W'(shift_sat({{(64-ACC_W){w_acc[ACC_W-1]}}, w_acc}, SHIFT, DATA_W));
    end
  end

  assign bus.in_ready  = w_accept;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign o_busy        = (r_state != IDLE);
  assign o_pass_done   = w_pass_done;
  assign o_cfg_err     = r_cfg_err;
  assign o_state       = r_state;
endmodule

// File: tb/tb_conv_tile_mac_engine.sv
module tb_conv_tile_mac_engine;
  import conv_tile_pkg::*;

  localparam int PX = 3, PY = 3, KM = 5, DW = 16, RW = PY + KM - 1;
  localparam int TW = PX * PY * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0;
  logic [3:0] i_kernel_size = '0;
  logic i_clear_acc = 1'b0;
  logic i_last_ch = 1'b0;
  logic o_busy, o_pass_done, o_cfg_err;
  state_t o_state;

  conv_tile_if #(.DATA_W(DW), .ROW_W(RW), .NOUT(PX*PY)) bus ();

  conv_tile_mac_engine #(
    .PARA_X(PX), .PARA_Y(PY), .KMAX(KM), .DATA_W(DW),
    .ACC_W(40), .SHIFT(0), .KS_W(4)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_kernel_size(i_kernel_size),
    .i_clear_acc(i_clear_acc), .i_last_ch(i_last_ch), .bus(bus),
    .o_busy(o_busy), .o_pass_done(o_pass_done), .o_cfg_err(o_cfg_err),
    .o_state(o_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- counters / scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [TW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  bit seen_ov = 0;
  int first_ov_cyc = 0;
  bit held = 0;
  logic [TW-1:0] held_data;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        if (!seen_ov) begin
          seen_ov = 1;
          first_ov_cyc = cyc;
        end
        if (held) chk("out_stable", bus.out_data, held_data);
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_tile: got %h expected none", bus.out_data);
          end else begin
            chk("tile", bus.out_data, exp_q.pop_front());
          end
          held = 0;
        end else begin
          held = 1;
          held_data = bus.out_data;
        end
      end else begin
        held = 0;
      end
    end else begin
      held = 0;
    end
  end

  // ---------------- stimulus data ----------------
  int tb_w  [KM][KM];
  int tb_px [PX+KM-1][RW];

  task automatic fill_w(input int v);
    for (int a = 0; a < KM; a++) for (int b = 0; b < KM; b++) tb_w[a][b] = v;
  endtask

  task automatic fill_px(input int v);
    for (int a = 0; a < PX+KM-1; a++) for (int b = 0; b < RW; b++) tb_px[a][b] = v;
  endtask

  function automatic logic [TW-1:0] tile_const(input int v);
    logic [TW-1:0] t;
    for (int i = 0; i < PX*PY; i++) t[i*DW +: DW] = DW'(v);
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [RW*DW-1:0] d, input bit stall);
    bit ok;
    int guard;
    if (stall) begin
      while ($urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    guard = 0;
    ok = 0;
    while (!ok && guard < 100) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL beat_timeout: got in_ready=0 expected 1");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_pass(input int k, input bit clr, input bit last, input bit stall);
    logic [RW*DW-1:0] d;
    i_start = 1'b1;
    i_kernel_size = 4'(k);
    i_clear_acc = clr;
    i_last_ch = last;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int n = 0; n < k*k; n++) begin
      d = '0;
      d[DW-1:0] = DW'(tb_w[n/k][n%k]);
      send_beat(d, stall);
    end
    for (int r = 0; r < PX+k-1; r++) begin
      for (int c = 0; c < RW; c++) d[c*DW +: DW] = DW'(tb_px[r][c]);
      send_beat(d, stall);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || o_busy) && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (g >= 400) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: got busy=%0d queue=%0d expected 0/0", o_busy, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"},     TW'(o_state), TW'(IDLE));
    chk({tag, "_in_ready"},  TW'(bus.in_ready), '0);
    chk({tag, "_out_valid"}, TW'(bus.out_valid), '0);
    chk({tag, "_out_data"},  bus.out_data, '0);
    chk({tag, "_busy"},      TW'(o_busy), '0);
    chk({tag, "_pass_done"}, TW'(o_pass_done), '0);
    chk({tag, "_cfg_err"},   TW'(o_cfg_err), '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [TW-1:0] e;
    int s_cyc, g;
    bit found;
    int bad_k[3];

    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;

    // K=3, all ones -> 9, latency 25
    fill_w(1); fill_px(1);
    exp_q.push_back(tile_const(9));
    seen_ov = 0;
    s_cyc = cyc;
    run_pass(3, 1, 1, 0);
    wait_idle();
    chk("latency_k3", TW'(first_ov_cyc - s_cyc), TW'(25));

    // K=5, centre tap 2, pixel 10r+c
    fill_w(0); tb_w[2][2] = 2;
    for (int r = 0; r < PX+KM-1; r++) for (int c = 0; c < RW; c++) tb_px[r][c] = 10*r + c;
    for (int x = 0; x < PX; x++) for (int y = 0; y < PY; y++)
      e[(x*PY+y)*DW +: DW] = DW'(2*(10*(x+2) + (y+2)));
    exp_q.push_back(e);
    run_pass(5, 1, 1, 0);
    wait_idle();

    // Two channels of all ones -> 18
    fill_w(1); fill_px(1);
    run_pass(3, 1, 0, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (o_pass_done) found = 1;
    end
    chk("pass_done_ch1", TW'(found), TW'(1));
    wait_idle();
    exp_q.push_back(tile_const(18));
    run_pass(3, 0, 1, 0);
    wait_idle();

    // Saturation high and low
    fill_w(32767); fill_px(32767);
    exp_q.push_back(tile_const(32767));
    run_pass(3, 1, 1, 0);
    wait_idle();
    fill_w(-32768);
    exp_q.push_back(tile_const(-32768));
    run_pass(3, 1, 1, 0);
    wait_idle();

    // Stalls plus 10 cycles of backpressure, K=5 vector again
    fill_w(0); tb_w[2][2] = 2;
    for (int r = 0; r < PX+KM-1; r++) for (int c = 0; c < RW; c++) tb_px[r][c] = 10*r + c;
    exp_q.push_back(e);
    bus.out_ready = 1'b0;
    run_pass(5, 1, 1, 1);
    g = 0;
    while (!bus.out_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("bp_out_valid", TW'(bus.out_valid), TW'(1));
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready", TW'(bus.in_ready), '0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_idle();

    // Illegal kernel sizes
    bad_k[0] = 4; bad_k[1] = 0; bad_k[2] = 7;
    for (int i = 0; i < 3; i++) begin
      i_start = 1'b1;
      i_kernel_size = 4'(bad_k[i]);
      @(posedge clk); #1;
      i_start = 1'b0;
      @(negedge clk);
      chk($sformatf("cfg_err_k%0d", bad_k[i]), TW'(o_cfg_err), TW'(1));
      chk($sformatf("cfg_busy_k%0d", bad_k[i]), TW'(o_busy), '0);
      @(posedge clk); #1;
    end

    // Reset in the middle of LOAD_PIX
    fill_w(1); fill_px(1);
    begin : mid_reset
      logic [RW*DW-1:0] d;
      i_start = 1'b1; i_kernel_size = 4'd3; i_clear_acc = 1'b1; i_last_ch = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      d = '0; d[DW-1:0] = DW'(1);
      for (int n = 0; n < 9; n++) send_beat(d, 0);
      d = tile_const(1)[RW*DW-1:0];
      for (int n = 0; n < 2; n++) send_beat(d, 0);
      chk("mid_state", TW'(o_state), TW'(LOAD_PIX));
      rst = 1'b1;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check_reset_vals("midrst");
      @(posedge clk); #1;
    end

    // Clean pass after reset
    exp_q.push_back(tile_const(9));
    run_pass(3, 1, 1, 0);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
